// File: rtl/spi_host.sv
// spi_host: SPI mode-3 host. Turns a valid/ready byte stream with a last flag into
// chip-select framed transfers and returns every received byte on a one-cycle strobe.
module spi_host #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic       i_spi_clk,
  input  logic       i_reset,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_last,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic       o_busy,
  output logic       o_sclk,
  output logic       o_cs_n,
  output logic       o_mosi,
  input  logic       i_miso
);
  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_MAX = 8'(CS_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  state_t     r_state, w_state_next;
  logic [7:0] r_div, w_div_next;
  logic [2:0] r_bit, w_bit_next;
  logic       r_phase, w_phase_next;
  logic [7:0] r_tx_sr, w_tx_sr_next;
  logic [7:0] r_rx_sr, w_rx_sr_next;
  logic       r_last, w_last_next;
  logic       r_sclk, w_sclk_next;
  logic       r_cs_n, w_cs_n_next;
  logic       r_mosi, w_mosi_next;
  logic       r_rx_valid, w_rx_valid_next;
  logic [7:0] r_rx_data, w_rx_data_next;
  logic       r_busy;
  logic       w_accept;

  assign o_tx_ready = ((r_state == ST_IDLE) || (r_state == ST_WAIT)) && !i_reset;
  assign w_accept   = i_tx_valid && o_tx_ready;

  assign o_sclk     = r_sclk;
  assign o_cs_n     = r_cs_n;
  assign o_mosi     = r_mosi;
  assign o_rx_valid = r_rx_valid;
  assign o_rx_data  = r_rx_data;
  assign o_busy     = r_busy;

  // Next-state and next-output decode; pin values are registered from these
  always_comb begin
    w_state_next    = r_state;
    w_div_next      = r_div;
    w_bit_next      = r_bit;
    w_phase_next    = r_phase;
    w_tx_sr_next    = r_tx_sr;
    w_rx_sr_next    = r_rx_sr;
    w_last_next     = r_last;
    w_sclk_next     = 1'b1;
    w_cs_n_next     = 1'b0;
    w_mosi_next     = r_mosi;
    w_rx_valid_next = 1'b0;
    w_rx_data_next  = r_rx_data;
    case (r_state)
      ST_IDLE: begin
        w_cs_n_next = 1'b1;
        if (w_accept) begin
          w_state_next = ST_SETUP;
          w_tx_sr_next = i_tx_data;
          w_last_next  = i_tx_last;
          w_div_next   = 8'd0;
          w_cs_n_next  = 1'b0;
        end else begin
          w_div_next = 8'd0;
        end
      end
      ST_SETUP: begin
        if (r_div == DIV_MAX) begin
          w_state_next = ST_SHIFT;
          w_div_next   = 8'd0;
          w_bit_next   = 3'd0;
          w_phase_next = 1'b0;
          w_sclk_next  = 1'b0;
          w_mosi_next  = r_tx_sr[7];
        end else begin
          w_div_next = r_div + 8'd1;
        end
      end
      ST_SHIFT: begin
        w_sclk_next = r_phase;
        // MISO is captured at the end of the first high cycle of each bit
        if (r_phase && (r_div == 8'd0)) begin
          w_rx_sr_next = {r_rx_sr[6:0], i_miso};
        end else begin
          w_rx_sr_next = r_rx_sr;
        end
        if (r_div != DIV_MAX) begin
          w_div_next = r_div + 8'd1;
        end else if (!r_phase) begin
          w_div_next   = 8'd0;
          w_phase_next = 1'b1;
          w_sclk_next  = 1'b1;
        end else if (r_bit != 3'd7) begin
          w_div_next   = 8'd0;
          w_phase_next = 1'b0;
          w_sclk_next  = 1'b0;
          w_bit_next   = r_bit + 3'd1;
          w_tx_sr_next = {r_tx_sr[6:0], 1'b0};
          w_mosi_next  = r_tx_sr[6];
        end else begin
          w_div_next      = 8'd0;
          w_rx_valid_next = 1'b1;
          w_rx_data_next  = w_rx_sr_next;
          w_state_next    = r_last ? ST_HOLD : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_accept) begin
          w_state_next = ST_SHIFT;
          w_tx_sr_next = i_tx_data;
          w_last_next  = i_tx_last;
          w_div_next   = 8'd0;
          w_bit_next   = 3'd0;
          w_phase_next = 1'b0;
          w_sclk_next  = 1'b0;
          w_mosi_next  = i_tx_data[7];
        end else begin
          w_div_next = 8'd0;
        end
      end
      ST_HOLD: begin
        if (r_div == DIV_MAX) begin
          w_state_next = ST_GAP;
          w_div_next   = 8'd0;
          w_cs_n_next  = 1'b1;
        end else begin
          w_div_next = r_div + 8'd1;
        end
      end
      ST_GAP: begin
        w_cs_n_next = 1'b1;
        if (r_div == GAP_MAX) begin
          w_state_next = ST_IDLE;
          w_div_next   = 8'd0;
        end else begin
          w_div_next = r_div + 8'd1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cs_n_next  = 1'b1;
        w_div_next   = 8'd0;
      end
    endcase
  end

  // State and pin registers; reset abandons any partial byte
  always_ff @(posedge i_spi_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_div      <= 8'd0;
      r_bit      <= 3'd0;
      r_phase    <= 1'b0;
      r_tx_sr    <= 8'd0;
      r_rx_sr    <= 8'd0;
      r_last     <= 1'b0;
      r_sclk     <= 1'b1;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= 8'd0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_div      <= w_div_next;
      r_bit      <= w_bit_next;
      r_phase    <= w_phase_next;
      r_tx_sr    <= w_tx_sr_next;
      r_rx_sr    <= w_rx_sr_next;
      r_last     <= w_last_next;
      r_sclk     <= w_sclk_next;
      r_cs_n     <= w_cs_n_next;
      r_mosi     <= w_mosi_next;
      r_rx_valid <= w_rx_valid_next;
      r_rx_data  <= w_rx_data_next;
      r_busy     <= (w_state_next != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_spi_host.sv
// Bench for spi_host: two instances (CLK_DIV=2/CS_GAP=4 and CLK_DIV=1/CS_GAP=2), a client
// model per instance, scoreboard queues popped by monitors, and a bus-rule checker.
`timescale 1ns/1ps
module tb_spi_host;
  localparam int D0 = 2;
  localparam int G0 = 4;
  localparam int D1 = 1;
  localparam int G1 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_q = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic       v0 = 1'b0, l0 = 1'b0, miso0 = 1'b0;
  logic [7:0] d0 = 8'd0;
  logic       rdy0, rxv0, busy0, sclk0, cs0, mosi0;
  logic [7:0] rxd0;
  logic       v1 = 1'b0, l1 = 1'b0, miso1 = 1'b0;
  logic [7:0] d1 = 8'd0;
  logic       rdy1, rxv1, busy1, sclk1, cs1, mosi1;
  logic [7:0] rxd1;

  logic       loop0 = 1'b1;
  logic [7:0] exp_rx0[$];
  logic [7:0] exp_rx1[$];
  logic [7:0] exp_mosi0[$];
  logic [7:0] resp0[$];

  spi_host #(.CLK_DIV(D0), .CS_GAP(G0)) u_dut0 (
    .i_spi_clk(clk), .i_reset(rst), .i_tx_valid(v0), .o_tx_ready(rdy0),
    .i_tx_data(d0), .i_tx_last(l0), .o_rx_valid(rxv0), .o_rx_data(rxd0),
    .o_busy(busy0), .o_sclk(sclk0), .o_cs_n(cs0), .o_mosi(mosi0), .i_miso(miso0)
  );

  spi_host #(.CLK_DIV(D1), .CS_GAP(G1)) u_dut1 (
    .i_spi_clk(clk), .i_reset(rst), .i_tx_valid(v1), .o_tx_ready(rdy1),
    .i_tx_data(d1), .i_tx_last(l1), .o_rx_valid(rxv1), .o_rx_data(rxd1),
    .o_busy(busy1), .o_sclk(sclk1), .o_cs_n(cs1), .o_mosi(mosi1), .i_miso(miso1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- instance 0 monitor, client and bus checker ----------------
  logic       p_sclk0 = 1'b1, p_cs0 = 1'b1, p_mosi0 = 1'b0, p_rxv0 = 1'b0, p_rdy0 = 1'b0;
  int         gap0 = 1000, falls0 = 0, frame_falls0 = 0, cli_cnt0 = 0;
  int         cs_fall0 = 0, cs_rise0 = 0, first_fall0 = 0, rx_cyc0 = 0, rdy_rise0 = 0;
  logic [7:0] cli_cur0 = 8'd0, cli_rx0 = 8'd0;

  always @(negedge clk) begin : mon0
    if (rxv0 === 1'b1) begin
      rx_cyc0 = cyc;
      chk("rx0_strobe_width", 32'(p_rxv0), 32'd0);
      if (exp_rx0.size() == 0) flag("rx0_unexpected_strobe");
      else chk("rx0_data", 32'(rxd0), 32'(exp_rx0.pop_front()));
    end
    if (!rst_q) begin
      chk("bus0_sclk_low_cs_high", 32'(cs0 & ~sclk0), 32'd0);
      if (cs0 != p_cs0) chk("bus0_sclk_at_cs_edge", 32'({p_sclk0, sclk0}), 32'd3);
      if (mosi0 != p_mosi0) chk("bus0_mosi_on_fall", 32'({p_sclk0, sclk0}), 32'd2);
      if (!cs0 && p_cs0) chk("bus0_cs_gap", 32'(gap0 >= G0), 32'd1);
    end
    if (!cs0 && p_cs0) begin
      cs_fall0 = cyc;
      falls0   = 0;
    end
    if (cs0 && !p_cs0) begin
      cs_rise0     = cyc;
      frame_falls0 = falls0;
      gap0         = 0;
    end
    if (cs0) gap0++;
    if (rst_q) gap0 = 1000;
    if (!sclk0 && p_sclk0 && !cs0) begin
      falls0++;
      if (falls0 == 1) first_fall0 = cyc;
    end
    if (rdy0 && !p_rdy0) rdy_rise0 = cyc;
    // Mode-3 client: drive MISO after SCLK falls, sample MOSI after SCLK rises
    if (cs0) begin
      cli_cnt0 = 0;
    end else begin
      if (!sclk0 && p_sclk0) begin
        if (cli_cnt0 == 0) begin
          if (!loop0 && resp0.size() > 0) cli_cur0 = resp0.pop_front();
          else cli_cur0 = 8'h00;
        end
        miso0    = loop0 ? mosi0 : cli_cur0[7];
        cli_cur0 = {cli_cur0[6:0], 1'b0};
      end
      if (sclk0 && !p_sclk0) begin
        cli_rx0 = {cli_rx0[6:0], mosi0};
        cli_cnt0++;
        if (cli_cnt0 == 8) begin
          cli_cnt0 = 0;
          if (exp_mosi0.size() == 0) flag("client0_unexpected_byte");
          else chk("client0_byte", 32'(cli_rx0), 32'(exp_mosi0.pop_front()));
        end
      end
    end
    p_sclk0 = sclk0;
    p_cs0   = cs0;
    p_mosi0 = mosi0;
    p_rxv0  = rxv0;
    p_rdy0  = rdy0;
  end

  // ---------------- instance 1 monitor, loopback client and bus checker ----------------
  logic p_sclk1 = 1'b1, p_cs1 = 1'b1, p_mosi1 = 1'b0, p_rxv1 = 1'b0, p_rdy1 = 1'b0;
  int   gap1 = 1000, falls1 = 0, frame_falls1 = 0;
  int   cs_fall1 = 0, cs_rise1 = 0, rx_cyc1 = 0, rdy_rise1 = 0;

  always @(negedge clk) begin : mon1
    if (rxv1 === 1'b1) begin
      rx_cyc1 = cyc;
      chk("rx1_strobe_width", 32'(p_rxv1), 32'd0);
      if (exp_rx1.size() == 0) flag("rx1_unexpected_strobe");
      else chk("rx1_data", 32'(rxd1), 32'(exp_rx1.pop_front()));
    end
    if (!rst_q) begin
      chk("bus1_sclk_low_cs_high", 32'(cs1 & ~sclk1), 32'd0);
      if (cs1 != p_cs1) chk("bus1_sclk_at_cs_edge", 32'({p_sclk1, sclk1}), 32'd3);
      if (mosi1 != p_mosi1) chk("bus1_mosi_on_fall", 32'({p_sclk1, sclk1}), 32'd2);
      if (!cs1 && p_cs1) chk("bus1_cs_gap", 32'(gap1 >= G1), 32'd1);
    end
    if (!cs1 && p_cs1) begin
      cs_fall1 = cyc;
      falls1   = 0;
    end
    if (cs1 && !p_cs1) begin
      cs_rise1     = cyc;
      frame_falls1 = falls1;
      gap1         = 0;
    end
    if (cs1) gap1++;
    if (rst_q) gap1 = 1000;
    if (!sclk1 && p_sclk1 && !cs1) begin
      falls1++;
      miso1 = mosi1;
    end
    if (rdy1 && !p_rdy1) rdy_rise1 = cyc;
    p_sclk1 = sclk1;
    p_cs1   = cs1;
    p_mosi1 = mosi1;
    p_rxv1  = rxv1;
    p_rdy1  = rdy1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int inst, input logic [7:0] d, input logic l, output int t0);
    int n;
    @(negedge clk);
    if (inst == 0) begin
      v0 = 1'b1; d0 = d; l0 = l;
    end else begin
      v1 = 1'b1; d1 = d; l1 = l;
    end
    n = 0;
    while (((inst == 0) ? rdy0 : rdy1) !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) flag("send_ready_timeout");
    t0 = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int inst);
    if (inst == 0) v0 = 1'b0;
    else v1 = 1'b0;
  endtask

  task automatic wait_ready(input int inst);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((inst == 0) ? rdy0 : rdy1) !== 1'b1 && n < 2000);
    if (n >= 2000) flag("wait_ready_timeout");
  endtask

  task automatic wait_idle(input int inst);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(((inst == 0) ? (rdy0 && !busy0) : (rdy1 && !busy1)) === 1'b1) && n < 2000);
    if (n >= 2000) flag("wait_idle_timeout");
    @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t1, t2, n;
    repeat (3) @(negedge clk);
    chk("reset_sclk", 32'(sclk0), 32'd1);
    chk("reset_cs_n", 32'(cs0), 32'd1);
    chk("reset_mosi", 32'(mosi0), 32'd0);
    chk("reset_rx_valid", 32'(rxv0), 32'd0);
    chk("reset_rx_data", 32'(rxd0), 32'd0);
    chk("reset_busy", 32'(busy0), 32'd0);
    chk("reset_ready", 32'(rdy0), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(rdy0), 32'd1);

    // Single-byte loopback frame
    loop0 = 1'b1;
    exp_rx0.push_back(8'hA5);
    exp_mosi0.push_back(8'hA5);
    send(0, 8'hA5, 1'b1, t1);
    idle(0);
    wait_idle(0);
    chk("single_cs_fall_cycle", 32'(cs_fall0 - t1), 32'd1);
    chk("single_first_fall_cycle", 32'(first_fall0 - t1), 32'(1 + D0));
    chk("single_rx_valid_cycle", 32'(rx_cyc0 - t1), 32'(1 + 17 * D0));
    chk("single_cs_low_len", 32'(cs_rise0 - cs_fall0), 32'd36);
    chk("single_sclk_falls", 32'(frame_falls0), 32'd8);
    chk("single_ready_gap", 32'(rdy_rise0 - cs_rise0), 32'd4);

    // Two-byte frame with client responses 0x81, 0x7E
    loop0 = 1'b0;
    resp0.push_back(8'h81);
    resp0.push_back(8'h7E);
    exp_rx0.push_back(8'h81);
    exp_rx0.push_back(8'h7E);
    exp_mosi0.push_back(8'h3C);
    exp_mosi0.push_back(8'hC3);
    send(0, 8'h3C, 1'b0, t1);
    send(0, 8'hC3, 1'b1, t2);
    idle(0);
    wait_idle(0);
    chk("pair_wait_one_cycle", 32'(t2 - t1), 32'(17 * D0 + 1));
    chk("pair_cs_low_len", 32'(cs_rise0 - cs_fall0), 32'd69);
    chk("pair_sclk_falls", 32'(frame_falls0), 32'd16);

    // Stalled source between bytes of one frame
    loop0 = 1'b1;
    exp_rx0.push_back(8'h11);
    exp_rx0.push_back(8'hFF);
    exp_mosi0.push_back(8'h11);
    exp_mosi0.push_back(8'hFF);
    send(0, 8'h11, 1'b0, t1);
    idle(0);
    wait_ready(0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("stall_cs_sclk_ready", 32'({cs0, sclk0, rdy0}), 32'd3);
    end
    send(0, 8'hFF, 1'b1, t2);
    idle(0);
    wait_idle(0);
    chk("stall_sclk_falls", 32'(frame_falls0), 32'd16);

    // Reset after the 4th SCLK fall of a byte
    send(0, 8'h96, 1'b1, t1);
    idle(0);
    repeat (2) @(negedge clk);
    n = 0;
    while (falls0 < 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) flag("midbyte_fall_timeout");
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_cs_n", 32'(cs0), 32'd1);
    chk("midreset_sclk", 32'(sclk0), 32'd1);
    chk("midreset_rx_valid", 32'(rxv0), 32'd0);
    chk("midreset_ready", 32'(rdy0), 32'd0);
    chk("midreset_busy", 32'(busy0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    exp_rx0.push_back(8'h5A);
    exp_mosi0.push_back(8'h5A);
    send(0, 8'h5A, 1'b1, t1);
    idle(0);
    wait_idle(0);
    chk("after_reset_sclk_falls", 32'(frame_falls0), 32'd8);

    // CLK_DIV=1 instance: back-to-back, stall, then a lone frame
    exp_rx1.push_back(8'h01);
    exp_rx1.push_back(8'h80);
    exp_rx1.push_back(8'hE7);
    exp_rx1.push_back(8'h42);
    send(1, 8'h01, 1'b0, t1);
    send(1, 8'h80, 1'b0, t2);
    chk("div1_b2b_period", 32'(t2 - t1), 32'd18);
    idle(1);
    wait_ready(1);
    repeat (3) @(negedge clk);
    send(1, 8'hE7, 1'b1, t2);
    idle(1);
    wait_idle(1);
    send(1, 8'h42, 1'b1, t1);
    idle(1);
    wait_idle(1);
    chk("div1_rx_valid_cycle", 32'(rx_cyc1 - t1), 32'd18);
    chk("div1_cs_low_len", 32'(cs_rise1 - cs_fall1), 32'd18);
    chk("div1_sclk_falls", 32'(frame_falls1), 32'd8);
    chk("div1_ready_gap", 32'(rdy_rise1 - cs_rise1), 32'(G1));

    repeat (5) @(negedge clk);
    chk("rx0_all_seen", 32'(exp_rx0.size()), 32'd0);
    chk("client0_all_seen", 32'(exp_mosi0.size()), 32'd0);
    chk("rx1_all_seen", 32'(exp_rx1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
